divider_scheduler: RTL and testbench
====================================

DIVIDER_SCHEDULER -- requirements
Module: divider_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_SIZE, 14, operand/quotient width; REMAINDER_SIZE, 8, fractional remainder width; NUM_CHANNELS, 4, requester count; TIMEOUT_CYCLES, 63, wait-state limit.
REQ-002 i_clock  in  1  single clock; all logic on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_request  in  NUM_CHANNELS  per-channel level request.
REQ-005 i_error  in  NUM_CHANNELS*DATA_SIZE  per-channel signed dividend; channel k at bits [k*DATA_SIZE +: DATA_SIZE].
REQ-006 i_reference  in  NUM_CHANNELS*DATA_SIZE  per-channel signed divisor, same packing.
REQ-007 o_grant  out  NUM_CHANNELS  one-hot, marks the channel being served.
REQ-008 o_done  out  NUM_CHANNELS  one-cycle completion pulse to the served channel.
REQ-009 o_quotient  out  DATA_SIZE; o_remainder  out  REMAINDER_SIZE: result of the last operation, held until the next completion.
REQ-010 o_div_by_zero  out  1; o_timeout  out  1: status flags, valid in the o_done cycle.
REQ-011 o_busy  out  1  high in every state except IDLE.
REQ-012 o_div_start  out  1; o_div_error  out  DATA_SIZE; o_div_reference  out  DATA_SIZE: request and operands to the divider.
REQ-013 i_div_valid  in  1; i_div_quotient  in  DATA_SIZE; i_div_remainder  in  REMAINDER_SIZE: divider result.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and DONE; all outputs registered.
REQ-015 IDLE: if any i_request bit is high, select one channel round-robin, starting at the channel after last_served; latch its operands into o_div_error/o_div_reference; set o_grant; go to ISSUE.
REQ-016 ISSUE with latched reference != 0: assert o_div_start for exactly one cycle; go to WAIT.
REQ-017 ISSUE with latched reference == 0: do not assert o_div_start; load o_quotient=0, o_remainder=0, o_div_by_zero=1; go to DONE.
REQ-018 WAIT: on i_div_valid, capture i_div_quotient/i_div_remainder into o_quotient/o_remainder; go to DONE.
REQ-019 DONE: pulse o_done for the granted channel for one cycle; set last_served to that channel; clear o_grant on exit; go to IDLE.
REQ-020 Latency: request seen in IDLE at cycle N gives o_div_start at N+1; o_done follows 1 cycle after i_div_valid is sampled.
REQ-021 i_div_valid outside WAIT SHALL be ignored.
REQ-022 Request deassertion after grant SHALL NOT abort the operation; operand changes after latch SHALL be ignored.
REQ-023 A channel re-requesting while granted SHALL be served again only after the other pending channels have been served.
REQ-024 o_div_by_zero and o_timeout SHALL clear on the next transition into ISSUE.
REQ-025 Back-to-back operation: after DONE, a new grant SHALL be possible in the immediately following IDLE cycle, with no extra idle gap.

Reset
REQ-026 On i_reset: state=IDLE; last_served=NUM_CHANNELS-1, so channel 0 wins first; all outputs 0; timeout counter 0.
REQ-027 Reset asserted in any state SHALL abandon the operation with no o_done pulse; a late i_div_valid after reset SHALL be ignored.

Configuration
REQ-028 Macro DIV_SCHEDULER_TIMEOUT_EN: when defined, a counter increments each WAIT cycle; if i_div_valid has not arrived after TIMEOUT_CYCLES+1 WAIT cycles, set o_quotient=0, o_remainder=0, o_timeout=1 and go to DONE.
REQ-029 Without DIV_SCHEDULER_TIMEOUT_EN: no counter; WAIT is held until i_div_valid; o_timeout SHALL be tied to 0.
REQ-030 If valid and timeout expiry coincide, valid SHALL win.

Verification
REQ-031 Channel 0: error=100, reference=7; model returns valid 18 cycles after start -> o_div_start 1 cycle after request, o_done=4'b0001, o_quotient=14.
REQ-032 All four requests high from reset -> grants in order 0,1,2,3,0, each with exactly one o_done pulse.
REQ-033 Channel 2: reference=0 -> no o_div_start, o_done=4'b0100, o_div_by_zero=1, quotient/remainder 0.
REQ-034 With TIMEOUT_EN defined and the model never returning valid -> o_timeout=1 and o_done exactly 64 WAIT cycles after entry; without it, state remains WAIT indefinitely.
REQ-035 i_reset pulsed during WAIT, then a stale i_div_valid -> no o_done, outputs 0, next request granted to channel 0.
REQ-036 Channel 1 drops i_request and changes operands during WAIT -> the operation completes with the original operands, and o_done[1] pulses.

Source files
------------

// File: rtl/divider_scheduler.sv
// divider_scheduler
//   Round-robin arbiter that shares a single external divider between
//   NUM_CHANNELS requesters. In IDLE it picks the next requesting channel,
//   starting after the last one served. It latches that channel's operands
//   and issues them to the divider. The divider result (or a forced zero
//   result) is returned with a one-cycle o_done pulse on the granted lane.
//
//   Optional build macro: DIV_SCHEDULER_TIMEOUT_EN
//     When defined, WAIT is bounded to TIMEOUT_CYCLES+1 cycles. On expiry
//     the result is forced to zero and o_timeout is flagged. When undefined,
//     there is no counter and o_timeout is tied low.
//
// Ports
//   i_clock, i_reset            rising-edge clock, synchronous active-high reset
//   i_request[NUM_CHANNELS]     per-channel level request
//   i_error, i_reference        packed per-channel signed dividend / divisor
//   o_grant, o_done             one-hot served channel / completion pulse
//   o_quotient, o_remainder     last result, held until the next completion
//   o_div_by_zero, o_timeout    status flags, valid in the o_done cycle
//   o_busy                      high whenever the FSM is not in IDLE
//   o_div_start, o_div_error,   request and operands to the divider
//   o_div_reference
//   i_div_valid, i_div_quotient, i_div_remainder   divider result
module divider_scheduler #(
    parameter int unsigned DATA_SIZE      = 14,
    parameter int unsigned REMAINDER_SIZE = 8,
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 63
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [NUM_CHANNELS-1:0]           i_request,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] i_error,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] i_reference,
    output logic [NUM_CHANNELS-1:0]           o_grant,
    output logic [NUM_CHANNELS-1:0]           o_done,
    output logic [DATA_SIZE-1:0]              o_quotient,
    output logic [REMAINDER_SIZE-1:0]         o_remainder,
    output logic                              o_div_by_zero,
    output logic                              o_timeout,
    output logic                              o_busy,
    output logic                              o_div_start,
    output logic [DATA_SIZE-1:0]              o_div_error,
    output logic [DATA_SIZE-1:0]              o_div_reference,
    input  logic                              i_div_valid,
    input  logic [DATA_SIZE-1:0]              i_div_quotient,
    input  logic [REMAINDER_SIZE-1:0]         i_div_remainder
);

    localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t r_state, w_state_next;

    logic [CH_W-1:0]           r_last_served, w_last_served_d;
    logic [CH_W-1:0]           r_sel, w_sel_d;
    logic [NUM_CHANNELS-1:0]   r_grant, w_grant_d;
    logic [NUM_CHANNELS-1:0]   r_done, w_done_d;
    logic [DATA_SIZE-1:0]      r_quotient, w_quotient_d;
    logic [REMAINDER_SIZE-1:0] r_remainder, w_remainder_d;
    logic                      r_div_by_zero, w_div_by_zero_d;
    logic                      r_timeout, w_timeout_d;
    logic                      r_busy, w_busy_d;
    logic                      r_div_start, w_div_start_d;
    logic [DATA_SIZE-1:0]      r_div_error, w_div_error_d;
    logic [DATA_SIZE-1:0]      r_div_reference, w_div_reference_d;

`ifdef DIV_SCHEDULER_TIMEOUT_EN
    localparam int unsigned CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [CNT_W-1:0] r_timeout_count, w_timeout_count_d;
    logic             w_expired;
    assign w_expired = (r_timeout_count == CNT_W'(TIMEOUT_CYCLES));
`endif

    // Unpacked views of the packed operand buses.
    logic [DATA_SIZE-1:0] w_ch_error [NUM_CHANNELS];
    logic [DATA_SIZE-1:0] w_ch_ref   [NUM_CHANNELS];

    always_comb begin
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            w_ch_error[k] = i_error[k*DATA_SIZE +: DATA_SIZE];
            w_ch_ref[k]   = i_reference[k*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Round-robin pick: scan starting one past the last served channel, so
    // a channel that keeps requesting yields to every other pending channel.
    logic [CH_W-1:0] w_pick;

    always_comb begin
        logic        found;
        int unsigned idx;
        w_pick = r_last_served;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            idx = (32'(r_last_served) + i) % NUM_CHANNELS;
            if (!found && i_request[CH_W'(idx)]) begin
                w_pick = CH_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (|i_request) w_state_next = StIssue;
            end
            StIssue: begin
                w_state_next = (r_div_reference == '0) ? StDone : StWait;
            end
            StWait: begin
                if (i_div_valid) w_state_next = StDone;
`ifdef DIV_SCHEDULER_TIMEOUT_EN
                else if (w_expired) w_state_next = StDone;
`endif
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Output / datapath next values; everything lands in a register.
    always_comb begin
        w_last_served_d   = r_last_served;
        w_sel_d           = r_sel;
        w_grant_d         = r_grant;
        w_done_d          = '0;
        w_quotient_d      = r_quotient;
        w_remainder_d     = r_remainder;
        w_div_by_zero_d   = r_div_by_zero;
        w_timeout_d       = r_timeout;
        w_div_start_d     = 1'b0;
        w_div_error_d     = r_div_error;
        w_div_reference_d = r_div_reference;
        w_busy_d          = (w_state_next != StIdle);
`ifdef DIV_SCHEDULER_TIMEOUT_EN
        w_timeout_count_d = r_timeout_count;
`endif
        unique case (r_state)
            StIdle: begin
                if (|i_request) begin
                    w_sel_d           = w_pick;
                    w_grant_d         = '0;
                    w_grant_d[w_pick] = 1'b1;
                    w_div_error_d     = w_ch_error[w_pick];
                    w_div_reference_d = w_ch_ref[w_pick];
                    // Start is raised while in ISSUE, only for a usable divisor.
                    w_div_start_d     = (w_ch_ref[w_pick] != '0);
                    w_div_by_zero_d   = 1'b0;
                    w_timeout_d       = 1'b0;
                end
            end
            StIssue: begin
                if (r_div_reference == '0) begin
                    w_quotient_d    = '0;
                    w_remainder_d   = '0;
                    w_div_by_zero_d = 1'b1;
                    w_done_d        = r_grant;
                end
`ifdef DIV_SCHEDULER_TIMEOUT_EN
                w_timeout_count_d = '0;
`endif
            end
            StWait: begin
                if (i_div_valid) begin
                    w_quotient_d  = i_div_quotient;
                    w_remainder_d = i_div_remainder;
                    w_done_d      = r_grant;
                end
`ifdef DIV_SCHEDULER_TIMEOUT_EN
                else if (w_expired) begin
                    w_quotient_d  = '0;
                    w_remainder_d = '0;
                    w_timeout_d   = 1'b1;
                    w_done_d      = r_grant;
                end else begin
                    w_timeout_count_d = r_timeout_count + 1'b1;
                end
`endif
            end
            StDone: begin
                w_last_served_d = r_sel;
                w_grant_d       = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_served   <= CH_W'(NUM_CHANNELS - 1);
            r_sel           <= '0;
            r_grant         <= '0;
            r_done          <= '0;
            r_quotient      <= '0;
            r_remainder     <= '0;
            r_div_by_zero   <= 1'b0;
            r_timeout       <= 1'b0;
            r_busy          <= 1'b0;
            r_div_start     <= 1'b0;
            r_div_error     <= '0;
            r_div_reference <= '0;
        end else begin
            r_last_served   <= w_last_served_d;
            r_sel           <= w_sel_d;
            r_grant         <= w_grant_d;
            r_done          <= w_done_d;
            r_quotient      <= w_quotient_d;
            r_remainder     <= w_remainder_d;
            r_div_by_zero   <= w_div_by_zero_d;
            r_timeout       <= w_timeout_d;
            r_busy          <= w_busy_d;
            r_div_start     <= w_div_start_d;
            r_div_error     <= w_div_error_d;
            r_div_reference <= w_div_reference_d;
        end
    end

`ifdef DIV_SCHEDULER_TIMEOUT_EN
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_timeout_count <= '0;
        end else begin
            r_timeout_count <= w_timeout_count_d;
        end
    end
`endif

    assign o_grant         = r_grant;
    assign o_done          = r_done;
    assign o_quotient      = r_quotient;
    assign o_remainder     = r_remainder;
    assign o_div_by_zero   = r_div_by_zero;
`ifdef DIV_SCHEDULER_TIMEOUT_EN
    assign o_timeout       = r_timeout;
`else
    assign o_timeout       = 1'b0;
`endif
    assign o_busy          = r_busy;
    assign o_div_start     = r_div_start;
    assign o_div_error     = r_div_error;
    assign o_div_reference = r_div_reference;

endmodule

// File: tb/tb_divider_scheduler.sv
module tb_divider_scheduler;

    localparam int DW = 14;
    localparam int RW = 8;
    localparam int NC = 4;

    logic            clk;
    logic            rst;
    logic [NC-1:0]   req;
    logic [NC*DW-1:0] err;
    logic [NC*DW-1:0] refv;
    logic [NC-1:0]   grant;
    logic [NC-1:0]   done;
    logic [DW-1:0]   quot;
    logic [RW-1:0]   rem;
    logic            dbz;
    logic            tmo;
    logic            busy;
    logic            start;
    logic [DW-1:0]   div_err;
    logic [DW-1:0]   div_ref;
    logic            dv;
    logic [DW-1:0]   dq;
    logic [RW-1:0]   dr;

    int total;
    int bad;

    divider_scheduler dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_request      (req),
        .i_error        (err),
        .i_reference    (refv),
        .o_grant        (grant),
        .o_done         (done),
        .o_quotient     (quot),
        .o_remainder    (rem),
        .o_div_by_zero  (dbz),
        .o_timeout      (tmo),
        .o_busy         (busy),
        .o_div_start    (start),
        .o_div_error    (div_err),
        .o_div_reference(div_ref),
        .i_div_valid    (dv),
        .i_div_quotient (dq),
        .i_div_remainder(dr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; sample point sits 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input int e, input int r);
        err[k*DW +: DW]  = DW'(e);
        refv[k*DW +: DW] = DW'(r);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        dv  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({grant, done, busy, start, dbz, tmo} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got grant=%b done=%b busy=%b start=%b dbz=%b tmo=%b want all 0",
                     grant, done, busy, start, dbz, tmo);
        end
        total++;
        if ({quot, rem, div_err, div_ref} !== '0) begin
            bad++;
            $display("FAIL reset_data got q=%0d r=%0d e=%0d ref=%0d want 0", quot, rem, div_err, div_ref);
        end
    endtask

    task automatic test_basic();
        int starts;
        set_ch(0, 100, 7);
        req = 4'b0001;
        tick();  // ISSUE
        starts = int'(start);
        total++;
        if (grant !== 4'b0001 || start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_issue got grant=%b start=%b busy=%b want 0001/1/1", grant, start, busy);
        end
        total++;
        if (div_err !== 14'd100 || div_ref !== 14'd7) begin
            bad++;
            $display("FAIL basic_operands got e=%0d r=%0d want 100/7", div_err, div_ref);
        end
        req = '0;
        for (int i = 0; i < 18; i++) begin
            tick();
            starts += int'(start);
            if (done !== '0) begin
                total++;
                bad++;
                $display("FAIL basic_early_done got=%b want=0000", done);
            end
        end
        dv = 1'b1;
        dq = 14'd14;
        dr = 8'd2;
        tick();  // DONE
        dv = 1'b0;
        total++;
        if (done !== 4'b0001 || quot !== 14'd14 || rem !== 8'd2 || dbz !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got done=%b q=%0d r=%0d dbz=%b want 0001/14/2/0", done, quot, rem, dbz);
        end
        total++;
        if (starts != 1) begin
            bad++;
            $display("FAIL basic_start_count got=%0d want=1", starts);
        end
        tick();  // IDLE
        total++;
        if (done !== '0 || grant !== '0 || busy !== 1'b0 || quot !== 14'd14) begin
            bad++;
            $display("FAIL basic_idle got done=%b grant=%b busy=%b q=%0d want 0000/0000/0/14",
                     done, grant, busy, quot);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        int         exp_k [5];
        exp_k = '{0, 1, 2, 3, 0};
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < NC; k++) set_ch(k, 10 * (k + 1), k + 1);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();  // ISSUE, directly from the previous IDLE cycle
            total++;
            if (grant !== exp_g[n] || div_err !== DW'(10 * (exp_k[n] + 1))) begin
                bad++;
                $display("FAIL rr_grant%0d got grant=%b e=%0d want %b/%0d", n, grant, div_err,
                         exp_g[n], 10 * (exp_k[n] + 1));
            end
            tick();  // WAIT
            dv = 1'b1;
            dq = DW'(n + 40);
            dr = '0;
            tick();  // DONE
            dv = 1'b0;
            total++;
            if (done !== exp_g[n] || quot !== DW'(n + 40)) begin
                bad++;
                $display("FAIL rr_done%0d got done=%b q=%0d want %b/%0d", n, done, quot, exp_g[n], n + 40);
            end
            tick();  // IDLE
            total++;
            if (done !== '0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rr_pulse%0d got done=%b busy=%b want 0000/0", n, done, busy);
            end
        end
        req = '0;
    endtask

    task automatic test_div_by_zero();
        set_ch(2, 55, 0);
        req = 4'b0100;
        tick();  // ISSUE
        total++;
        if (grant !== 4'b0100 || start !== 1'b0) begin
            bad++;
            $display("FAIL dbz_issue got grant=%b start=%b want 0100/0", grant, start);
        end
        req = '0;
        tick();  // DONE
        total++;
        if (done !== 4'b0100 || dbz !== 1'b1 || quot !== '0 || rem !== '0 || start !== 1'b0) begin
            bad++;
            $display("FAIL dbz_done got done=%b dbz=%b q=%0d r=%0d start=%b want 0100/1/0/0/0",
                     done, dbz, quot, rem, start);
        end
        tick();  // IDLE, flag held
        total++;
        if (done !== '0 || dbz !== 1'b1) begin
            bad++;
            $display("FAIL dbz_hold got done=%b dbz=%b want 0000/1", done, dbz);
        end
    endtask

    task automatic test_operand_change();
        set_ch(1, 200, 9);
        req = 4'b0010;
        tick();  // ISSUE; flag from the zero-divisor case clears here
        total++;
        if (grant !== 4'b0010 || dbz !== 1'b0 || start !== 1'b1) begin
            bad++;
            $display("FAIL opch_issue got grant=%b dbz=%b start=%b want 0010/0/1", grant, dbz, start);
        end
        req = '0;
        set_ch(1, 1, 1);
        tick();  // WAIT
        tick();
        total++;
        if (div_err !== 14'd200 || div_ref !== 14'd9 || busy !== 1'b1) begin
            bad++;
            $display("FAIL opch_latched got e=%0d r=%0d busy=%b want 200/9/1", div_err, div_ref, busy);
        end
        dv = 1'b1;
        dq = 14'd22;
        dr = 8'd5;
        tick();  // DONE
        dv = 1'b0;
        total++;
        if (done !== 4'b0010 || quot !== 14'd22 || rem !== 8'd5) begin
            bad++;
            $display("FAIL opch_done got done=%b q=%0d r=%0d want 0010/22/5", done, quot, rem);
        end
        tick();
    endtask

    task automatic test_stale_valid();
        dv = 1'b1;
        dq = 14'd99;
        dr = 8'd9;
        tick();
        tick();
        dv = 1'b0;
        total++;
        if (done !== '0 || busy !== 1'b0 || quot !== 14'd22) begin
            bad++;
            $display("FAIL stale_idle got done=%b busy=%b q=%0d want 0000/0/22", done, busy, quot);
        end
    endtask

    task automatic test_reset_in_wait();
        set_ch(3, 30, 3);
        req = 4'b1000;
        tick();  // ISSUE
        req = '0;
        tick();  // WAIT
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dv  = 1'b1;
        dq  = 14'd77;
        dr  = 8'd7;
        tick();
        dv = 1'b0;
        total++;
        if ({grant, done, busy, start, dbz, tmo} !== '0 || quot !== '0 || rem !== '0) begin
            bad++;
            $display("FAIL rstwait_outputs got grant=%b done=%b busy=%b q=%0d r=%0d want all 0",
                     grant, done, busy, quot, rem);
        end
        tick();
        total++;
        if (done !== '0) begin
            bad++;
            $display("FAIL rstwait_nodone got=%b want=0000", done);
        end
        req = 4'b1111;
        tick();
        req = '0;
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL rstwait_regrant got=%b want=0001", grant);
        end
    endtask

    task automatic test_timeout();
        int dones;
        do_reset();
        set_ch(0, 100, 7);
        req = 4'b0001;
        tick();  // ISSUE
        req = '0;
        tick();  // first WAIT cycle
        dones = 0;
`ifdef DIV_SCHEDULER_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            tick();
            dones += int'(|done);
        end
        total++;
        if (dones != 0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_early got dones=%0d busy=%b want 0/1", dones, busy);
        end
        tick();  // DONE after 64 WAIT cycles
        total++;
        if (done !== 4'b0001 || tmo !== 1'b1 || quot !== '0 || rem !== '0) begin
            bad++;
            $display("FAIL tmo_done got done=%b tmo=%b q=%0d r=%0d want 0001/1/0/0", done, tmo, quot, rem);
        end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            dones += int'(|done);
        end
        total++;
        if (dones != 0 || busy !== 1'b1 || tmo !== 1'b0) begin
            bad++;
            $display("FAIL tmo_hold got dones=%0d busy=%b tmo=%b want 0/1/0", dones, busy, tmo);
        end
        dv = 1'b1;
        dq = 14'd14;
        dr = 8'd2;
        tick();
        dv = 1'b0;
        total++;
        if (done !== 4'b0001 || quot !== 14'd14) begin
            bad++;
            $display("FAIL tmo_late_valid got done=%b q=%0d want 0001/14", done, quot);
        end
`endif
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;
        err   = '0;
        refv  = '0;
        dv    = 1'b0;
        dq    = '0;
        dr    = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_div_by_zero();
        test_operand_change();
        test_stale_valid();
        test_reset_in_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
